// File: rtl/feature_packer.sv
// feature_packer: front end for the 784-input network core.
// Thresholds a valid/ready stream of 8-bit pixels into a packed feature vector,
// freezes that vector while the registered network pipeline settles, then
// captures the network's prediction and offers it on a valid/ready result port.
module feature_packer #(
    parameter int N_PIX     = 784,
    parameter int THRESHOLD = 128,
    parameter int LATENCY   = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [7:0]       pix_data,
    input  logic             pix_last,
    output logic [N_PIX-1:0] features,
    input  logic [3:0]       prediction_in,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [3:0]       result,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_count
);

    // Index into the feature vector and settle-counter widths.
    localparam int IDX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
    localparam int SET_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PIX - 1);
    localparam logic [SET_W-1:0] SET_DONE = SET_W'(LATENCY);
    // Nine bits so a threshold of 256 (no pixel passes) is still representable.
    localparam logic [8:0]       THR      = 9'(THRESHOLD);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [SET_W-1:0]   set_cnt_q;
    logic [N_PIX-1:0]   features_q;
    logic [3:0]         result_q;
    logic               result_valid_q;
    logic               frame_err_q;
    logic [CNT_W-1:0]   frame_count_q;

    logic               accept_s;
    logic               pix_bit_s;

    // Unsigned threshold compare of one pixel.
    function automatic logic pix_threshold(input logic [7:0] d);
        return ({1'b0, d} >= THR);
    endfunction

    // Ready is combinational so a beat can land in the same cycle the FSM
    // re-enters FILL; reset forces it low immediately.
    assign pix_ready = (state_q == S_FILL) && rst_n;
    assign accept_s  = pix_valid && pix_ready;
    assign pix_bit_s = pix_threshold(pix_data);

    // Frame assembly, settle timing and result capture in one state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_FILL;
            idx_q          <= '0;
            set_cnt_q      <= '0;
            features_q     <= '0;
            result_q       <= 4'd0;
            result_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_count_q  <= '0;
        end else begin
            // Error flag is a single-cycle pulse unless re-armed below.
            frame_err_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    if (accept_s) begin
                        if (idx_q == IDX_LAST) begin
                            // Final bit: frame is kept even if pix_last was missing.
                            features_q[idx_q] <= pix_bit_s;
                            idx_q             <= '0;
                            set_cnt_q         <= '0;
                            state_q           <= S_SETTLE;
                            frame_err_q       <= ~pix_last;
                        end else if (pix_last) begin
                            // Short frame: discard it entirely and start over.
                            features_q  <= '0;
                            idx_q       <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            features_q[idx_q] <= pix_bit_s;
                            idx_q             <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_q <= idx_q;
                    end
                end
                S_SETTLE: begin
                    // Sample the network LATENCY+1 edges after the last bit was written.
                    if (set_cnt_q == SET_DONE) begin
                        result_q       <= prediction_in;
                        result_valid_q <= 1'b1;
                        state_q        <= S_RESULT;
                    end else begin
                        set_cnt_q <= set_cnt_q + SET_W'(1);
                    end
                end
                S_RESULT: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        frame_count_q  <= frame_count_q + CNT_W'(1);
                        state_q        <= S_FILL;
                    end else begin
                        result_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= S_FILL;
                    idx_q          <= '0;
                    set_cnt_q      <= '0;
                    result_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign features     = features_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign frame_err    = frame_err_q;
    assign frame_count  = frame_count_q;

endmodule
